divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider.sv | 127 ++++++++++++
 tb/tb_divider.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Multi-cycle restoring radix-2 divider for signed and unsigned operands.
// Divide-by-zero and signed overflow finish in one cycle; everything else takes WIDTH iterations.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dividend_sh;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] partial_rem;
  logic [WIDTH-1:0] quo_acc;
  logic             q_neg;
  logic             r_neg;

  logic             accept;
  logic             op1_neg;
  logic             op2_neg;
  logic [WIDTH-1:0] op1_mag;
  logic [WIDTH-1:0] op2_mag;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  always_comb begin
    accept   = start && (state != BUSY);
    op1_neg  = signed_op && operand_1[WIDTH-1];
    op2_neg  = signed_op && operand_2[WIDTH-1];
    op1_mag  = op1_neg ? -operand_1 : operand_1;
    op2_mag  = op2_neg ? -operand_2 : operand_2;
    div_zero = (operand_2 == '0);
    overflow = signed_op && (operand_1 == MOST_NEG) && (operand_2 == '1);
  end

  // One restoring step: a borrow out of the WIDTH+1-bit subtract means the divisor did not fit.
  always_comb begin
    trial    = {partial_rem, dividend_sh[WIDTH-1]} - {1'b0, divisor_mag};
    rem_next = trial[WIDTH] ? {partial_rem[WIDTH-2:0], dividend_sh[WIDTH-1]}
                            : trial[WIDTH-1:0];
    quo_next = {quo_acc[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = (div_zero || overflow) ? DONE : BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (count == LAST_ITER) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (accept) state_next = (div_zero || overflow) ? DONE : BUSY;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      dividend_sh <= '0;
      divisor_mag <= '0;
      partial_rem <= '0;
      quo_acc     <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else if (accept) begin
      count       <= '0;
      dividend_sh <= op1_mag;
      divisor_mag <= op2_mag;
      partial_rem <= '0;
      quo_acc     <= '0;
      q_neg       <= op1_neg ^ op2_neg;
      r_neg       <= op1_neg;
      if (div_zero) begin
        quotient  <= '1;
        remainder <= operand_1;
      end else if (overflow) begin
        quotient  <= MOST_NEG;
        remainder <= '0;
      end
    end else if (state == BUSY) begin
      count       <= count + 1'b1;
      dividend_sh <= dividend_sh << 1;
      partial_rem <= rem_next;
      quo_acc     <= quo_next;
      if (count == LAST_ITER) begin
        quotient  <= q_neg ? -quo_next : quo_next;
        remainder <= r_neg ? -rem_next : rem_next;
      end
    end
  end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expected results, a negedge monitor checks each done pulse.
module tb_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;
  int   done_seen;

  divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .signed_op (signed_op),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation, including its arrival cycle.
  always @(negedge clk) begin
    if (done) begin
      done_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput({e.name, "_quotient"}, quotient, e.q);
        checkOutput({e.name, "_remainder"}, remainder, e.r);
        checkOutput({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Assumes the caller is sitting on a negedge; leaves start low one cycle later with scrambled operands.
  task automatic pulseStart(input logic s, input logic [31:0] a, input logic [31:0] b);
    signed_op = s;
    operand_1 = a;
    operand_2 = b;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    signed_op = ~s;
    operand_1 = ~a;
    operand_2 = 32'h3;
  endtask

  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] q, input logic [31:0] r, input int lat,
                               input string name);
    exp_t e;
    @(negedge clk);
    e.q    = q;
    e.r    = r;
    e.cyc  = cyc + lat;
    e.name = name;
    sb.push_back(e);
    pulseStart(s, a, b);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish by 100000 expected earlier finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    done_seen = 0;
    reset     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    operand_1 = '0;
    operand_2 = '0;

    #2 reset = 1'b1;
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_quotient", quotient, 32'd0);
    checkOutput("reset_remainder", remainder, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 100 / 7 unsigned with busy tracked on every cycle of the operation
    applyStimulus(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, "u100_7");
    for (int i = 1; i <= 32; i++) begin
      checkOutput($sformatf("u100_7_busy_c%0d", i), 32'(busy), 32'd1);
      @(negedge clk);
    end
    checkOutput("u100_7_busy_c33", 32'(busy), 32'd0);
    waitDrain();

    applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, "s_m7_2");
    waitDrain();
    applyStimulus(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33, "s_7_m2");
    waitDrain();
    applyStimulus(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 33, "s_m100_m7");
    waitDrain();

    applyStimulus(1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1, "u_div0");
    waitDrain();
    applyStimulus(1'b1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1, "s_div0");
    waitDrain();
    applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1, "s_ovf");
    waitDrain();
    applyStimulus(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33, "u_big");
    waitDrain();

    applyStimulus(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 33, "u_max_1");
    waitDrain();
    applyStimulus(1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 33, "u_5_9");
    waitDrain();

    // A second start mid-flight is ignored; a start during DONE launches the next operation
    applyStimulus(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, "ignore_busy");
    repeat (8) @(negedge clk);
    @(negedge clk);
    pulseStart(1'b0, 32'd50, 32'd3);
    repeat (21) @(negedge clk);
    applyStimulus(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 33, "start_in_done");
    checkOutput("start_in_done_busy", 32'(busy), 32'd1);
    checkOutput("hold_quotient", quotient, 32'd14);
    checkOutput("hold_remainder", remainder, 32'd2);
    waitDrain();

    // Asynchronous abort mid-operation
    @(negedge clk);
    pulseStart(1'b0, 32'd100, 32'd7);
    repeat (14) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_quotient", quotient, 32'd0);
    checkOutput("abort_remainder", remainder, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    repeat (40) @(negedge clk);
    checkOutput("abort_no_done", 32'(done_seen), 32'd0);

    applyStimulus(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, "after_abort");
    waitDrain();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: got %0d expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
